// File: rtl/dmem_responder.sv
// Wait-state data-memory responder for the MEM stage: holds the pipeline while an
// access is outstanding, then completes it with a one-cycle done pulse.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic [3:0]            r_be;
  logic [31:0]           r_rdata;
  logic                  r_done;
  logic                  r_err;
  logic [31:0]           r_mem [2**ADDR_WIDTH];

  logic                  w_misaligned;
  logic                  w_accept;
  logic                  w_access;
  logic                  w_unused_addr;

  // Upper address bits alias onto the array.
  assign w_unused_addr = ^req_addr[31:ADDR_WIDTH+2];

  assign w_misaligned = (req_be == 4'b1111) && (req_addr[1:0] != 2'b00);
  assign w_accept     = (r_state == S_IDLE) && req_valid && !w_misaligned;
  assign w_access     = (r_state == S_BUSY) && (r_cnt == 4'd0);

  // Combinational so the accepting cycle already holds the pipeline.
  assign stall = !reset && (w_accept || (r_state == S_BUSY));

  assign rdata = r_rdata;
  assign done  = r_done;
  assign err   = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_rdata <= 32'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_misaligned) begin
              r_err <= 1'b1;
            end else begin
              r_write <= req_write;
              r_idx   <= req_addr[ADDR_WIDTH+1:2];
              r_wdata <= req_wdata;
              r_be    <= req_be;
              r_cnt   <= 4'(WAIT_CYCLES);
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (!r_write) r_rdata <= r_mem[r_idx];
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the array is deliberately kept out of reset so it maps onto a RAM macro;
  // a store interrupted by reset never reaches here because r_state is already IDLE.
  always_ff @(posedge clk) begin
    if (w_access && r_write) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with two wait states, one with none,
// sharing a request bus; sel picks which instance sees req_valid.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        sel;

  logic        stall_w2, stall_w0, done_w2, done_w0, err_w2, err_w0;
  logic [31:0] rdata_w2, rdata_w0;
  logic        stall, done, err;
  logic [31:0] rdata;

  int          n_checks = 0;
  int          n_errors = 0;

  logic [31:0] mdl [2][256];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .stall(stall_w2), .rdata(rdata_w2), .done(done_w2), .err(err_w2)
  );

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .stall(stall_w0), .rdata(rdata_w0), .done(done_w0), .err(err_w0)
  );

  assign stall = sel ? stall_w0 : stall_w2;
  assign done  = sel ? done_w0  : done_w2;
  assign err   = sel ? err_w0   : err_w2;
  assign rdata = sel ? rdata_w0 : rdata_w2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Update the reference model and scoreboard at the moment a request is driven.
  task automatic model_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be);
    int s = sel ? 1 : 0;
    logic [7:0] idx = a[9:2];
    if (wr) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mdl[s][idx][8*i +: 8] = wd[8*i +: 8];
    end else begin
      exp_q.push_back(mdl[s][idx]);
      last_rd[s] = mdl[s][idx];
    end
  endtask

  // One complete access; checks stall length, done timing and load data.
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be);
    int wc  = sel ? 0 : 2;
    int nst = 0;
    bit got = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_be = be;
    model_req(wr, a, wd, be);
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (stall) nst++;
      if (done) begin
        got = 1'b1;
        check("done_cycle", c, wc + 2);
        check("stall_len", nst, wc + 2);
        if (!wr) check("load_rdata", rdata, exp_q.pop_front());
      end
      @(posedge clk); #1;
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd_before;
    logic        st_pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        dn_pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    sel = 1'b0; reset = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wdata = 32'd0; req_be = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall_forced", stall, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_rdata", rdata, 32'd0);
    req_valid = 1'b0;
    reset = 1'b0;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;

    // Full-word store then load
    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    access(1'b0, 32'h10, 32'd0, 4'hF);

    // Byte lanes
    access(1'b1, 32'h20, 32'h11223344, 4'hF);
    access(1'b1, 32'h20, 32'h0000AA00, 4'b0010);
    access(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000);
    access(1'b0, 32'h20, 32'd0, 4'hF);
    check("model_lanes", mdl[0][8'h08], 32'h1122AA44);

    // Misaligned word access
    rd_before = last_rd[0];
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h22; req_be = 4'hF;
    @(negedge clk);
    check("misal_stall", stall, 1'b0);
    check("misal_err_early", err, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("misal_err", err, 1'b1);
    check("misal_no_done", done, 1'b0);
    check("misal_rdata", rdata, rd_before);
    @(negedge clk);
    check("misal_err_pulse", err, 1'b0);

    // Reset in the middle of a store
    access(1'b1, 32'h30, 32'h00000000, 4'hF);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(negedge clk);
    check("rst_mid_stall0", stall, 1'b1);
    @(posedge clk); #2;
    check("rst_mid_busy", stall, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_mid_stall_drop", stall, 1'b0);
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rst_mid_no_done", done, 1'b0);
    end
    reset = 1'b0;
    access(1'b0, 32'h30, 32'd0, 4'hF);

    // Aliasing
    access(1'b1, 32'h004, 32'h5A5A5A5A, 4'hF);
    access(1'b0, 32'h404, 32'd0, 4'hF);

    // Zero wait states: preload, then back-to-back loads with req_valid held through DONE
    sel = 1'b1;
    access(1'b1, 32'h40, 32'h01234567, 4'hF);
    access(1'b1, 32'h44, 32'h89ABCDEF, 4'hF);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b0; req_be = 4'hF;
      req_addr = (c < 3) ? 32'h40 : 32'h44;
      if (c == 0 || c == 3) model_req(1'b0, req_addr, 32'd0, 4'hF);
      @(negedge clk);
      check($sformatf("b2b_stall_c%0d", c), stall, st_pat[c]);
      check($sformatf("b2b_done_c%0d", c), done, dn_pat[c]);
      if (done && exp_q.size() > 0) check("b2b_rdata", rdata, exp_q.pop_front());
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_idle_stall", stall, 1'b0);
    check("b2b_idle_done", done, 1'b0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
